// File: rtl/uart_rx_module.sv
// 8N1 UART receiver: synchronised input, mid-bit sampling, 1-entry valid/ready buffer.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_module #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_bitCnt;
  logic [2:0]             r_idx;
  logic [7:0]             r_shift;
  logic                   r_deliver;
  logic                   w_srx;
  logic                   w_bitEnd;

  assign w_srx    = r_sync[SYNC_STAGES-1];
  assign w_bitEnd = (r_bitCnt == LAST_CNT);

`ifdef UART_RX_PARITY_EN
  logic r_parityErr;
  assign parity_err = r_parityErr;
`else
  assign parity_err = 1'b0;
`endif

  // Delivery is deferred one cycle after the stop sample so the buffer logic
  // sees a settled shift register, independent of what the FSM does next.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sync    <= '1;
      r_bitCnt  <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_deliver <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parityErr <= 1'b0;
`endif
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], rx_pin_in};
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parityErr <= 1'b0;
`endif
      r_bitCnt <= w_bitEnd ? '0 : r_bitCnt + CW'(1);

      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (r_deliver) begin
        r_deliver <= 1'b0;
        if (!rx_valid || rx_ready) begin
          rx_data  <= r_shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (!w_srx) begin
            r_state  <= S_START;
            r_bitCnt <= '0;
          end
        end
        // Half a bit in: confirm the start bit and realign the counter to mid-bit.
        S_START: begin
          if (r_bitCnt == HALF_CNT) begin
            r_bitCnt <= '0;
            r_idx    <= '0;
            r_state  <= w_srx ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_bitEnd) begin
            r_shift <= {w_srx, r_shift[7:1]};
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bitEnd) begin
            r_parityErr <= ^{r_shift, w_srx};
            r_state     <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_bitEnd) begin
            if (w_srx) begin
              r_deliver <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              r_state   <= S_BREAK;
            end
          end
        end
        // A held-low line must return high before another start bit counts.
        S_BREAK: begin
          if (w_srx) begin
            r_state  <= S_IDLE;
            r_bitCnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_module.sv
// Self-checking bench for uart_rx_module: directed scenarios plus random bytes,
// checked against a frame-level model (bytes sent vs bytes handed over).
module tb_uart_rx_module;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int EXP_LAT = SYNC + (19 * CPB) / 2 + 1 + CPB;
`else
  localparam int EXP_LAT = SYNC + (19 * CPB) / 2 + 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_pin_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  uart_rx_module #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_pin_in (rx_pin_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;

  logic [7:0] rxQ[$];
  int   feCnt, ovCnt, peCnt, vCycles, stabErr;
  int   startCyc, lastRiseCyc;
  logic prevValid, prevAccept;
  logic [7:0] prevData;
  logic sendBadParity = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: records handed-over bytes, flag pulses and buffer stability.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prevValid  = 1'b0;
      prevAccept = 1'b0;
    end else begin
      if (rx_valid === 1'b1 && rx_ready === 1'b1) rxQ.push_back(rx_data);
      if (frame_err !== 1'b0) feCnt++;
      if (overrun !== 1'b0) ovCnt++;
      if (parity_err !== 1'b0) peCnt++;
      if (rx_valid === 1'b1) vCycles++;
      if (rx_valid === 1'b1 && !prevValid) lastRiseCyc = cyc;
      if (prevValid && rx_valid === 1'b1 && rx_data !== prevData && !prevAccept) stabErr++;
      prevValid  = (rx_valid === 1'b1);
      prevAccept = (rx_valid === 1'b1 && rx_ready === 1'b1);
      prevData   = rx_data;
    end
  end

  task automatic clear_mon();
    rxQ.delete();
    feCnt = 0; ovCnt = 0; peCnt = 0; vCycles = 0; stabErr = 0;
  endtask

  task automatic idle(input int n);
    rx_pin_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_pin_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Serial frame: start 0, data LSB first, optional even parity, stop.
  task automatic send_frame(input logic [7:0] d, input logic stopBit);
    startCyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(sendBadParity ? ~(^d) : ^d);
`endif
    send_bit(stopBit);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_pin_in = 1'b1; rx_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    nChecks++;
    if (rx_valid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid: got %b expected 0", rx_valid); end
    nChecks++;
    if (rx_data !== 8'h00) begin nFail++; $display("[TB] FAIL reset_data: got %h expected 00", rx_data); end
    nChecks++;
    if ({frame_err, overrun, parity_err} !== 3'b000)
      begin nFail++; $display("[TB] FAIL reset_flags: got %b expected 000", {frame_err, overrun, parity_err}); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    clear_mon();
    rx_ready = 1'b1;
    idle(5);
    send_frame(8'hA5, 1'b1);
    idle(4);
    nChecks++;
    if (rxQ.size() != 1 || rxQ[0] !== 8'hA5)
      begin nFail++; $display("[TB] FAIL single_data: got %0d bytes first %h expected 1 byte A5", rxQ.size(), rxQ.size() ? rxQ[0] : 8'hxx); end
    nChecks++;
    if (vCycles != 1) begin nFail++; $display("[TB] FAIL single_valid_width: got %0d cycles expected 1", vCycles); end
    nChecks++;
    if (feCnt + ovCnt + peCnt != 0)
      begin nFail++; $display("[TB] FAIL single_flags: got fe=%0d ov=%0d pe=%0d expected 0", feCnt, ovCnt, peCnt); end
    // The pin changes just after an edge, so the edge-counted latency lands at or just above the nominal.
    nChecks++;
    if (lastRiseCyc - startCyc < EXP_LAT - 1 || lastRiseCyc - startCyc > EXP_LAT + 1)
      begin nFail++; $display("[TB] FAIL single_latency: got %0d expected %0d +/-1", lastRiseCyc - startCyc, EXP_LAT); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(4);
    nChecks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h3C)
      begin nFail++; $display("[TB] FAIL b2b_hold: got valid=%b data=%h expected 1 3C", rx_valid, rx_data); end
    nChecks++;
    if (ovCnt != 1) begin nFail++; $display("[TB] FAIL b2b_overrun: got %0d pulses expected 1", ovCnt); end
    nChecks++;
    if (stabErr != 0 || feCnt != 0)
      begin nFail++; $display("[TB] FAIL b2b_stable: got stab=%0d fe=%0d expected 0 0", stabErr, feCnt); end
    rx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if (rx_valid !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_drop: got valid=%b expected 0", rx_valid); end
    nChecks++;
    if (rxQ.size() != 1 || rxQ[0] !== 8'h3C)
      begin nFail++; $display("[TB] FAIL b2b_accept: got %0d bytes first %h expected 1 byte 3C", rxQ.size(), rxQ.size() ? rxQ[0] : 8'hxx); end
  endtask

  task automatic test_framing();
    clear_mon();
    send_frame(8'h55, 1'b0);
    rx_pin_in = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    idle(20);
    send_frame(8'h12, 1'b1);
    idle(4);
    nChecks++;
    if (feCnt != 1) begin nFail++; $display("[TB] FAIL frame_err_pulse: got %0d expected 1", feCnt); end
    nChecks++;
    if (rxQ.size() != 1 || rxQ[0] !== 8'h12)
      begin nFail++; $display("[TB] FAIL frame_recover: got %0d bytes first %h expected 1 byte 12", rxQ.size(), rxQ.size() ? rxQ[0] : 8'hxx); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx_pin_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(40);
    nChecks++;
    if (vCycles + feCnt + ovCnt + peCnt != 0)
      begin nFail++; $display("[TB] FAIL glitch_quiet: got v=%0d fe=%0d ov=%0d pe=%0d expected all 0", vCycles, feCnt, ovCnt, peCnt); end
    send_frame(8'h5A, 1'b1);
    idle(4);
    nChecks++;
    if (rxQ.size() != 1 || rxQ[0] !== 8'h5A)
      begin nFail++; $display("[TB] FAIL glitch_after: got %0d bytes first %h expected 1 byte 5A", rxQ.size(), rxQ.size() ? rxQ[0] : 8'hxx); end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    repeat (CPB / 2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    nChecks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00)
      begin nFail++; $display("[TB] FAIL midreset_clear: got valid=%b data=%h expected 0 00", rx_valid, rx_data); end
    @(posedge clk); #1;
    idle(40);
    send_frame(8'h81, 1'b1);
    idle(4);
    nChecks++;
    if (rxQ.size() != 1 || rxQ[0] !== 8'h81 || feCnt + ovCnt + peCnt != 0)
      begin nFail++; $display("[TB] FAIL midreset_next: got %0d bytes first %h flags %0d expected 1 byte 81 flags 0", rxQ.size(), rxQ.size() ? rxQ[0] : 8'hxx, feCnt + ovCnt + peCnt); end
  endtask

  task automatic test_random();
    logic [7:0] expQ[$];
    logic [7:0] b;
    clear_mon();
    rx_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom);
      expQ.push_back(b);
      send_frame(b, 1'b1);
      if ($urandom_range(0, 1) == 1) send_bit(1'b1);
      idle($urandom_range(0, 20));
    end
    idle(4);
    nChecks++;
    if (rxQ.size() != expQ.size())
      begin nFail++; $display("[TB] FAIL random_count: got %0d expected %0d", rxQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
      nChecks++;
      if (rxQ[i] !== expQ[i]) begin nFail++; $display("[TB] FAIL random_byte%0d: got %h expected %h", i, rxQ[i], expQ[i]); end
    end
    nChecks++;
    if (feCnt + ovCnt + peCnt != 0)
      begin nFail++; $display("[TB] FAIL random_flags: got fe=%0d ov=%0d pe=%0d expected 0", feCnt, ovCnt, peCnt); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_mon();
    rx_ready = 1'b1;
    sendBadParity = 1'b1;
    send_frame(8'h07, 1'b1);
    sendBadParity = 1'b0;
    idle(4);
    nChecks++;
    if (peCnt != 1 || rxQ.size() != 1 || rxQ[0] !== 8'h07)
      begin nFail++; $display("[TB] FAIL parity_bad: got pe=%0d bytes=%0d expected pe=1 one byte 07", peCnt, rxQ.size()); end
    clear_mon();
    send_frame(8'h07, 1'b1);
    idle(4);
    nChecks++;
    if (peCnt != 0 || rxQ.size() != 1 || rxQ[0] !== 8'h07)
      begin nFail++; $display("[TB] FAIL parity_good: got pe=%0d bytes=%0d expected pe=0 one byte 07", peCnt, rxQ.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_reset_midframe();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
